// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX/MEM hazard inputs and pipeline-register controls.
// The slave modport belongs to hazard_ctrl; the master modport to the pipeline datapath.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [4:0]       ID_Rs1_addr;
  logic [4:0]       ID_Rs2_addr;
  logic             ID_Rs1_used;
  logic             ID_Rs2_used;
  logic             EX_MemRead;
  logic [4:0]       EX_Rd_addr;
  logic             EX_redirect;
  logic             MEM_mem_req;
  logic             mem_ready;
  logic             PC_en;
  logic             IF_ID_en;
  logic             IF_ID_flush;
  logic             ID_EX_en;
  logic             ID_EX_flush;
  logic             EX_MEM_en;
  logic             MEM_WB_en;
  logic             MEM_WB_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_Rs1_addr, ID_Rs2_addr, ID_Rs1_used, ID_Rs2_used,
           EX_MemRead, EX_Rd_addr, EX_redirect, MEM_mem_req, mem_ready,
    input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
           EX_MEM_en, MEM_WB_en, MEM_WB_flush, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  ID_Rs1_addr, ID_Rs2_addr, ID_Rs1_used, ID_Rs2_used,
           EX_MemRead, EX_Rd_addr, EX_redirect, MEM_mem_req, mem_ready,
    output PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
           EX_MEM_en, MEM_WB_en, MEM_WB_flush, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline with data-memory wait watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int unsigned WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;
  logic            timeout_q, timeout_d;

  logic mem_stall;
  logic load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, mem_wb_flush;

  always_comb begin
    mem_stall = hz.MEM_mem_req && !hz.mem_ready;
    load_use  = hz.EX_MemRead && (hz.EX_Rd_addr != 5'd0) &&
                ((hz.ID_Rs1_used && (hz.ID_Rs1_addr == hz.EX_Rd_addr)) ||
                 (hz.ID_Rs2_used && (hz.ID_Rs2_addr == hz.EX_Rd_addr)));

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;

    if (rst || state_q == ERROR) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_stall) begin
      // Freeze everything up to MEM; WB keeps draining with a bubble.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (hz.EX_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!hz.MEM_mem_req || hz.mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          if (wait_q != '1) wait_d = wait_q + WC_W'(1);
          if (MEM_TIMEOUT != 0 && wait_q == WC_LAST) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end
        end
      end
      ERROR: state_d = ERROR;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && state_q != ERROR && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    if (if_id_flush && flush_q != '1) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_count  = {CNT_W{1'b0}};
`endif

  assign hz.PC_en        = pc_en;
  assign hz.IF_ID_en     = if_id_en;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_en     = id_ex_en;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.EX_MEM_en    = ex_mem_en;
  assign hz.MEM_WB_en    = mem_wb_en;
  assign hz.MEM_WB_flush = mem_wb_flush;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls, a negedge monitor checks them.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  // {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en, MEM_WB_flush}
  localparam logic [7:0] C_ZERO   = 8'b0000_0000;
  localparam logic [7:0] C_NORM   = 8'b1101_0110;
  localparam logic [7:0] C_MSTALL = 8'b0000_0011;
  localparam logic [7:0] C_REDIR  = 8'b1111_1110;
  localparam logic [7:0] C_LUSE   = 8'b0001_1110;

  typedef struct {
    string            name;
    logic [7:0]       ctrl;
    logic             to;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] sc_model = '0;
  logic [CNT_W-1:0] fc_model = '0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic r,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic mr, input logic [4:0] rd, input logic redir,
                      input logic mreq, input logic mrdy,
                      input logic [7:0] ctrl, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    hz.ID_Rs1_addr = rs1;
    hz.ID_Rs1_used = u1;
    hz.ID_Rs2_addr = rs2;
    hz.ID_Rs2_used = u2;
    hz.EX_MemRead  = mr;
    hz.EX_Rd_addr  = rd;
    hz.EX_redirect = redir;
    hz.MEM_mem_req = mreq;
    hz.mem_ready   = mrdy;
    if (r) begin
      sc_model = '0;
      fc_model = '0;
    end
    e.name = name;
    e.ctrl = ctrl;
    e.to   = to;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = sc_model;
    e.fc = fc_model;
`else
    e.sc = '0;
    e.fc = '0;
`endif
    exp_q.push_back(e);
    // Zero controls only occur in reset or ERROR, neither of which counts as a stall.
    if (!r && !ctrl[7] && ctrl != C_ZERO) sc_model = sc_model + 1;
    if (!r && ctrl[5]) fc_model = fc_model + 1;
  endtask

  task automatic idle(input string name, input logic r, input logic mreq, input logic mrdy,
                      input logic [7:0] ctrl, input logic to);
    step(name, r, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, mreq, mrdy, ctrl, to);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = exp_q.pop_front();
      act = {hz.PC_en, hz.IF_ID_en, hz.IF_ID_flush, hz.ID_EX_en, hz.ID_EX_flush,
             hz.EX_MEM_en, hz.MEM_WB_en, hz.MEM_WB_flush};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
      end
      checks++;
      if (hz.mem_timeout !== e.to) begin
        errors++;
        $display("FAIL %s mem_timeout: got %b expected %b", e.name, hz.mem_timeout, e.to);
      end
      checks++;
      if (hz.stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, hz.stall_cycles, e.sc);
      end
      checks++;
      if (hz.flush_count !== e.fc) begin
        errors++;
        $display("FAIL %s flush_count: got %0d expected %0d", e.name, hz.flush_count, e.fc);
      end
    end
  end

  initial begin
    hz.ID_Rs1_addr = '0; hz.ID_Rs1_used = 1'b0;
    hz.ID_Rs2_addr = '0; hz.ID_Rs2_used = 1'b0;
    hz.EX_MemRead  = 1'b0; hz.EX_Rd_addr = '0; hz.EX_redirect = 1'b0;
    hz.MEM_mem_req = 1'b0; hz.mem_ready  = 1'b0;

    idle("reset",       1'b1, 1'b0, 1'b0, C_ZERO, 1'b0);
    idle("post_reset",  1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    // Load-use on rs1, then the load has moved on.
    step("lu_rs1",      1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LUSE, 1'b0);
    step("lu_release",  1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_rs2",      1'b0, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LUSE, 1'b0);
    step("lu_rs2_unused", 1'b0, 5'd1, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_x0",       1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    step("lu_noload",   1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    step("redir_lu",    1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_REDIR, 1'b0);
    idle("after_redir", 1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    idle("single_access", 1'b0, 1'b1, 1'b1, C_NORM, 1'b0);
    // Three wait cycles then completion.
    for (int unsigned i = 0; i < 3; i++) idle("mwait", 1'b0, 1'b1, 1'b0, C_MSTALL, 1'b0);
    idle("mwait_done",  1'b0, 1'b1, 1'b1, C_NORM, 1'b0);
    idle("run_again",   1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    // Redirect held across a memory stall fires on release.
    for (int unsigned i = 0; i < 2; i++)
      step("mwait_redir", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_MSTALL, 1'b0);
    step("redir_release", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_REDIR, 1'b0);
    // Request dropped during wait returns to RUN.
    idle("drop_wait",   1'b0, 1'b1, 1'b0, C_MSTALL, 1'b0);
    idle("drop_req",    1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    idle("drop_run",    1'b0, 1'b1, 1'b1, C_NORM, 1'b0);
    // Reset in the middle of a stall.
    idle("rst_wait",    1'b0, 1'b1, 1'b0, C_MSTALL, 1'b0);
    idle("rst_mid",     1'b1, 1'b1, 1'b0, C_ZERO, 1'b0);
    idle("rst_after",   1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    // Watchdog with MEM_TIMEOUT=4.
    for (int unsigned i = 0; i < 4; i++) idle("to_wait", 1'b0, 1'b1, 1'b0, C_MSTALL, 1'b0);
    idle("to_error",    1'b0, 1'b1, 1'b0, C_ZERO, 1'b1);
    idle("to_ready",    1'b0, 1'b1, 1'b1, C_ZERO, 1'b1);
    step("to_redir",    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_ZERO, 1'b1);
    idle("to_rst",      1'b1, 1'b0, 1'b0, C_ZERO, 1'b0);
    idle("to_recover",  1'b0, 1'b0, 1'b0, C_NORM, 1'b0);
    idle("to_recover_lu_free", 1'b0, 1'b1, 1'b1, C_NORM, 1'b0);

    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
